// File: rtl/burst_read_master.sv
// rtl/burst_read_master.sv - Avalon-MM burst read master with credit-limited show-ahead data FIFO
module burst_read_master #(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int LENGTH_WIDTH      = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_COUNT       = 8,
    parameter int BURST_WIDTH       = 4,
    parameter int FIFO_DEPTH        = 32,
    parameter int FIFO_DEPTH_LOG2   = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_read,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic                         master_waitrequest,
    input  logic [DATA_WIDTH-1:0]        master_readdata,
    input  logic                         master_readdatavalid,
    input  logic                         ctrl_start,
    input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
    input  logic [LENGTH_WIDTH-1:0]      ctrl_length,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    output logic [DATA_WIDTH-1:0]        user_data,
    output logic                         user_valid,
    input  logic                         user_ready
);
    localparam int PW = FIFO_DEPTH_LOG2 + 1;
    localparam int CW = FIFO_DEPTH_LOG2 + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_next;

    logic [LENGTH_WIDTH-1:0]    remaining;
    logic [LENGTH_WIDTH-1:0]    next_remaining;
    logic [PW-1:0]              pending;
    logic [PW-1:0]              fifo_used;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [BURST_WIDTH-1:0]     burst;
    logic [BURST_WIDTH-1:0]     next_burst;
    logic [CW-1:0]              credit;
    logic [CW-1:0]              next_credit;
    logic                       accept;
    logic                       push;
    logic                       pop;

    function automatic logic [BURST_WIDTH-1:0] burst_of(input logic [LENGTH_WIDTH-1:0] r);
        if (r < LENGTH_WIDTH'(BURST_COUNT))
            return r[BURST_WIDTH-1:0];
        else
            return BURST_WIDTH'(BURST_COUNT);
    endfunction

    assign accept = master_read && !master_waitrequest;
    // beats arriving with nothing outstanding are protocol violations (or pre-reset leftovers)
    assign push   = master_readdatavalid && (pending != '0);
    assign pop    = user_valid && user_ready;

    assign burst          = burst_of(remaining);
    assign next_remaining = remaining - LENGTH_WIDTH'(master_burstcount);
    assign next_burst     = burst_of(next_remaining);
    // credit counts FIFO slots not yet claimed by stored or in-flight beats
    assign credit         = CW'(FIFO_DEPTH) - CW'(fifo_used) - CW'(pending);
    assign next_credit    = credit - CW'(master_burstcount) + CW'(pop);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (ctrl_start && ctrl_length != '0) state_next = ISSUE;
            ISSUE:   if (remaining == '0 && !master_read) state_next = DRAIN;
            DRAIN:   if (pending == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ctrl_busy         = (state != IDLE);
        master_byteenable = '1;
        user_valid        = (fifo_used != '0);
        user_data         = user_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            master_address    <= '0;
            master_read       <= 1'b0;
            master_burstcount <= '0;
            remaining         <= '0;
            pending           <= '0;
            ctrl_done         <= 1'b0;
        end else begin
            ctrl_done <= (state == IDLE && ctrl_start && ctrl_length == '0) ||
                         (state == DRAIN && pending == '0);
            pending   <= pending + (accept ? PW'(master_burstcount) : PW'(0)) - PW'(push);
            case (state)
                IDLE: begin
                    if (ctrl_start && ctrl_length != '0) begin
                        master_address <= ctrl_baseaddress;
                        remaining      <= ctrl_length;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        master_address <= master_address +
                                          ADDRESS_WIDTH'(master_burstcount) * ADDRESS_WIDTH'(BYTE_ENABLE_WIDTH);
                        remaining      <= next_remaining;
                        // keep read high for a back-to-back burst when it already fits
                        if (next_remaining != '0 && next_credit >= CW'(next_burst)) begin
                            master_read       <= 1'b1;
                            master_burstcount <= next_burst;
                        end else begin
                            master_read       <= 1'b0;
                        end
                    end else if (!master_read && remaining != '0 && credit >= CW'(burst)) begin
                        master_read       <= 1'b1;
                        master_burstcount <= burst;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_used <= fifo_used + PW'(push) - PW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= master_readdata;
    end
endmodule
